axis_sample_tx: RTL and testbench

//  AXI-Stream transmitter feeding the network input port (axis_in_data/valid/ready).

---
 rtl/axis_sample_tx.sv | 150 +++++++++++++++
 tb/tb_axis_sample_tx.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_tx.sv
// Sample buffer plus AXI-Stream transmitter: the host loads words, pulses start, and the block
// streams NUM_SAMPLES words with TLAST on the final one and a done pulse afterwards.
module axis_sample_tx #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_SAMPLES = 784,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  soft_reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_drop,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [ADDR_WIDTH:0] NumW    = (ADDR_WIDTH+1)'(NUM_SAMPLES);
  localparam logic [ADDR_WIDTH:0] LastIdx = (ADDR_WIDTH+1)'(NUM_SAMPLES - 1);
  localparam logic [ADDR_WIDTH:0] OneIdx  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {StIdle, StPrime, StStream, StDone} state_e;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  state_e                state_q;
  logic [ADDR_WIDTH:0]   rd_idx_q;
  logic [DATA_WIDTH-1:0] pf_data_q;
  logic                  pf_last_q;
  logic                  pf_vld_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wr_drop_q;

  logic out_free;
  logic last_beat;
  logic pf_take;
  logic pf_fill;
  logic wr_ok;

  always_comb begin
    out_free  = !tvalid_q || m_axis_tready;
    last_beat = tvalid_q && m_axis_tready && tlast_q;
    pf_take   = (state_q == StStream) && out_free && pf_vld_q && !last_beat;
    // Prefetch stage refills in the same cycle it hands its word to the output register.
    pf_fill   = (state_q == StStream) && (!pf_vld_q || pf_take) && (rd_idx_q < NumW);
    wr_ok     = wr_en && ((state_q == StIdle) || (state_q == StDone)) &&
                ({1'b0, wr_addr} < NumW);
  end

  // Buffer is intentionally outside both resets.
  always_ff @(posedge s_axi_aclk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= StIdle;
      rd_idx_q  <= '0;
      pf_data_q <= '0;
      pf_last_q <= 1'b0;
      pf_vld_q  <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else if (soft_reset) begin
      state_q   <= StIdle;
      rd_idx_q  <= '0;
      pf_data_q <= '0;
      pf_last_q <= 1'b0;
      pf_vld_q  <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      wr_drop_q <= wr_en && !wr_ok;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StPrime;
            busy_q   <= 1'b1;
            rd_idx_q <= '0;
          end
        end
        StPrime: begin
          pf_data_q <= mem_q[0];
          pf_last_q <= (NUM_SAMPLES == 1);
          pf_vld_q  <= 1'b1;
          rd_idx_q  <= OneIdx;
          state_q   <= StStream;
        end
        StStream: begin
          if (last_beat) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (out_free) begin
            tvalid_q <= pf_vld_q;
            if (pf_vld_q) begin
              tdata_q <= pf_data_q;
              tlast_q <= pf_last_q;
            end
          end
          if (pf_fill) begin
            pf_data_q <= mem_q[rd_idx_q[ADDR_WIDTH-1:0]];
            pf_last_q <= (rd_idx_q == LastIdx);
            pf_vld_q  <= 1'b1;
            rd_idx_q  <= rd_idx_q + OneIdx;
          end else if (pf_take) begin
            pf_vld_q <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_drop       = wr_drop_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_sample_tx.sv
// Directed bench for axis_sample_tx: a 4-sample instance for the main scenarios and a
// 1-sample instance for the single-beat vector.
module tb_axis_sample_tx;

  logic        clk;
  logic        rst_n;
  logic        soft_reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        tready;
  logic        busy, done, wr_drop, tvalid, tlast;
  logic [15:0] tdata;

  logic        wr_en1;
  logic [1:0]  wr_addr1;
  logic [15:0] wr_data1;
  logic        start1;
  logic        tready1;
  logic        busy1, done1, wr_drop1, tvalid1, tlast1;
  logic [15:0] tdata1;

  int n_cmp;
  int n_bad;

  logic [15:0] exp_w [4];

  axis_sample_tx #(.DATA_WIDTH(16), .NUM_SAMPLES(4), .ADDR_WIDTH(3)) u_dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .soft_reset    (soft_reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .wr_drop       (wr_drop),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  axis_sample_tx #(.DATA_WIDTH(16), .NUM_SAMPLES(1), .ADDR_WIDTH(2)) u_dut1 (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .soft_reset    (soft_reset),
    .wr_en         (wr_en1),
    .wr_addr       (wr_addr1),
    .wr_data       (wr_data1),
    .start         (start1),
    .busy          (busy1),
    .done          (done1),
    .wr_drop       (wr_drop1),
    .m_axis_tdata  (tdata1),
    .m_axis_tvalid (tvalid1),
    .m_axis_tready (tready1),
    .m_axis_tlast  (tlast1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0 || tvalid !== 1'b0 ||
        tlast !== 1'b0 || tdata !== 16'h0) begin
      n_bad++;
      $display("FAIL reset: got busy=%b done=%b drop=%b v=%b l=%b d=%h, want all 0",
               busy, done, wr_drop, tvalid, tlast, tdata);
    end
    #3 rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = exp_w[i];
      tick;
    end
    wr_en = 1'b0;
    n_cmp++;
    if (wr_drop !== 1'b0) begin
      n_bad++; $display("FAIL basic_wr_drop: got %b want 0", wr_drop);
    end
    tready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || tvalid !== 1'b0) begin
      n_bad++; $display("FAIL basic_prime: got busy=%b v=%b want busy=1 v=0", busy, tvalid);
    end
    tick;
    n_cmp++;
    if (tvalid !== 1'b0) begin
      n_bad++; $display("FAIL basic_latency: got v=%b one cycle after start, want 0", tvalid);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++;
      if (tvalid !== 1'b1 || tdata !== exp_w[i] || tlast !== 1'(i == 3)) begin
        n_bad++;
        $display("FAIL basic_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, tvalid, tdata, tlast, exp_w[i], (i == 3));
      end
    end
    tick;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done: got done=%b busy=%b v=%b want 1 0 0", done, busy, tvalid);
    end
    tick;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL basic_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_backpressure;
    logic [5:0]  pat;
    logic [15:0] held;
    logic        held_last;
    int          nb;
    bit          stall;
    bit          seen_done;
    pat = 6'b101001;
    nb = 0; stall = 1'b0; seen_done = 1'b0; held = '0; held_last = 1'b0;
    tready = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      if (stall) begin
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== held || tlast !== held_last) begin
          n_bad++;
          $display("FAIL bp_stall: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   tvalid, tdata, tlast, held, held_last);
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        n_cmp++;
        if (nb != 4) begin
          n_bad++; $display("FAIL bp_done_early: got %0d beats at done, want 4", nb);
        end
      end else begin
        tready = pat[k % 6];
        stall = 1'b0;
        if (tvalid === 1'b1 && tready) begin
          n_cmp++;
          if (nb >= 4) begin
            n_bad++; $display("FAIL bp_extra_beat: got beat %0d d=%h, want only 4", nb, tdata);
          end else if (tdata !== exp_w[nb] || tlast !== 1'(nb == 3)) begin
            n_bad++;
            $display("FAIL bp_beat%0d: got d=%h l=%b want d=%h l=%b",
                     nb, tdata, tlast, exp_w[nb], (nb == 3));
          end
          nb++;
        end else if (tvalid === 1'b1) begin
          stall = 1'b1; held = tdata; held_last = tlast;
        end
        tick;
      end
    end
    n_cmp++;
    if (!seen_done) begin
      n_bad++; $display("FAIL bp_timeout: got no done within 40 cycles, want done");
    end
    tready = 1'b1;
    tick;
  endtask

  task automatic test_busy_ignore;
    tready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hBEEF;
    tick;
    start = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (wr_drop !== 1'b1 || tdata !== 16'h0022 || tvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_drop: got drop=%b v=%b d=%h want drop=1 v=1 d=0022",
               wr_drop, tvalid, tdata);
    end
    tick;
    n_cmp++;
    if (wr_drop !== 1'b0 || tdata !== 16'h0033) begin
      n_bad++; $display("FAIL busy_cont: got drop=%b d=%h want drop=0 d=0033", wr_drop, tdata);
    end
    tick;
    tick;
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL busy_done: got done=%b want 1", done);
    end
    tick;
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_restart_ignored: got v=%b busy=%b want 0 0", tvalid, busy);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++;
      if (tvalid !== 1'b1 || tdata !== exp_w[i]) begin
        n_bad++;
        $display("FAIL busy_rerun%0d: got v=%b d=%h want v=1 d=%h", i, tvalid, tdata, exp_w[i]);
      end
    end
    tick;
    tick;
  endtask

  task automatic test_write_range;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hDEAD;
    tick;
    wr_en = 1'b0;
    n_cmp++;
    if (wr_drop !== 1'b1) begin
      n_bad++; $display("FAIL oor_drop: got drop=%b want 1", wr_drop);
    end
    tick;
    n_cmp++;
    if (wr_drop !== 1'b0) begin
      n_bad++; $display("FAIL oor_drop_pulse: got drop=%b want 0", wr_drop);
    end
    // Write to word 0 coinciding with start: the new word must go out first.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0055; start = 1'b1;
    tick;
    wr_en = 1'b0; start = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++;
      if (tvalid !== 1'b1 || tdata !== ((i == 0) ? 16'h0055 : exp_w[i])) begin
        n_bad++;
        $display("FAIL wr_start_beat%0d: got v=%b d=%h want v=1 d=%h", i, tvalid, tdata,
                 (i == 0) ? 16'h0055 : exp_w[i]);
      end
    end
    tick;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = exp_w[0];
    tick;
    wr_en = 1'b0;
    n_cmp++;
    if (wr_drop !== 1'b0) begin
      n_bad++; $display("FAIL done_write: got drop=%b want 0", wr_drop);
    end
    tick;
  endtask

  task automatic test_soft_reset;
    tready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    tick;
    n_cmp++;
    if (tdata !== 16'h0033 || tvalid !== 1'b1) begin
      n_bad++; $display("FAIL sr_pre: got v=%b d=%h want v=1 d=0033", tvalid, tdata);
    end
    soft_reset = 1'b1;
    tick;
    soft_reset = 1'b0;
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tlast !== 1'b0) begin
      n_bad++;
      $display("FAIL sr_abort: got v=%b busy=%b done=%b l=%b want all 0",
               tvalid, busy, done, tlast);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (done !== 1'b0 || tvalid !== 1'b0) begin
        n_bad++; $display("FAIL sr_quiet%0d: got done=%b v=%b want 0 0", i, done, tvalid);
      end
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== 16'h0011) begin
      n_bad++; $display("FAIL sr_restart: got v=%b d=%h want v=1 d=0011", tvalid, tdata);
    end
    tick;
    tick;
    tick;
    tick;
    tick;
  endtask

  task automatic test_async_and_single;
    tready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || tdata !== 16'h0 || tlast !== 1'b0 ||
        done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst: got v=%b busy=%b d=%h l=%b done=%b want all 0",
               tvalid, busy, tdata, tlast, done);
    end
    tick;
    #2 rst_n = 1'b1;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== 16'h0011) begin
      n_bad++; $display("FAIL async_buf_kept: got v=%b d=%h want v=1 d=0011", tvalid, tdata);
    end
    tick; tick; tick; tick; tick;
    wr_en1 = 1'b1; wr_addr1 = 2'd0; wr_data1 = 16'h00AB;
    tick;
    wr_en1 = 1'b0; tready1 = 1'b1; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    tick;
    tick;
    n_cmp++;
    if (tvalid1 !== 1'b1 || tdata1 !== 16'h00AB || tlast1 !== 1'b1) begin
      n_bad++;
      $display("FAIL single_beat: got v=%b d=%h l=%b want v=1 d=00ab l=1", tvalid1, tdata1, tlast1);
    end
    tick;
    n_cmp++;
    if (done1 !== 1'b1 || tvalid1 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: got done=%b v=%b busy=%b want 1 0 0", done1, tvalid1, busy1);
    end
    tick;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    exp_w = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    rst_n = 1'b0; soft_reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; tready = 1'b0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; start1 = 1'b0; tready1 = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_busy_ignore;
    test_write_range;
    test_soft_reset;
    test_async_and_single;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
